// File: rtl/cpu_pkg.sv
// Shared opcode, state and strobe definitions for the Mini SRC control sequencer.
// CU_MULDIV_EN enables the mul/div execute sequence; otherwise they decode as nop.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BRX  = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_OP_ADD = OP_ADD;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef struct packed {
        logic       pc_out;
        logic       mdr_out;
        logic       zlow_out;
        logic       zhigh_out;
        logic       lo_out;
        logic       hi_out;
        logic       inport_out;
        logic       ba_out;
        logic       c_out;
        logic       r_out;
        logic       pc_enable;
        logic       inc_pc;
        logic       mar_enable;
        logic       mdr_enable;
        logic       mdr_read;
        logic       ram_write;
        logic       ir_enable;
        logic       y_enable;
        logic       zlow_in;
        logic       zhigh_in;
        logic       hi_enable;
        logic       lo_enable;
        logic       r_in;
        logic       con_enable;
        logic       outport_enable;
        logic       gra;
        logic       grb;
        logic       grc;
        logic [4:0] alu_op;
        logic       run;
    } strobes_t;

    // Number of execute steps (T3 onward) before returning to T0.
    function automatic logic [2:0] exec_cycles(input logic [4:0] op);
        logic [2:0] n;
        case (op)
            OP_LD, OP_ST:                                   n = 3'd5;
            OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR,
            OP_ROL, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: n = 3'd3;
            OP_NEG, OP_NOT:                                 n = 3'd2;
            OP_BRX:                                         n = 3'd4;
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV:                                 n = 3'd4;
`endif
            default:                                        n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cu_step_decode.sv
// Combinational map from {state, opcode, CON_FF} to the full datapath strobe set.
// CU_MULDIV_EN selects whether mul/div get their own execute steps.
import cpu_pkg::*;

module cu_step_decode (
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    output strobes_t   strobes
);

    always_comb begin
        strobes     = '0;
        strobes.run = 1'b1;
        case (state)
            ST_T0: begin
                strobes.pc_out = 1'b1; strobes.mar_enable = 1'b1;
                strobes.inc_pc = 1'b1; strobes.zlow_in    = 1'b1;
            end
            ST_T1: begin
                strobes.zlow_out = 1'b1; strobes.pc_enable  = 1'b1;
                strobes.mdr_read = 1'b1; strobes.mdr_enable = 1'b1;
            end
            ST_T2: begin
                strobes.mdr_out = 1'b1; strobes.ir_enable = 1'b1;
            end
            ST_T3: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_enable = 1'b1;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_enable = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1;
                        strobes.alu_op = opcode; strobes.zlow_in = 1'b1;
                    end
`ifdef CU_MULDIV_EN
                    OP_MUL, OP_DIV: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.y_enable = 1'b1;
                    end
`endif
                    OP_BRX: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.con_enable = 1'b1;
                    end
                    OP_JR: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_enable = 1'b1;
                    end
                    OP_IN: begin
                        strobes.inport_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    OP_OUT: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.outport_enable = 1'b1;
                    end
                    OP_MFHI: begin
                        strobes.hi_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    OP_MFLO: begin
                        strobes.lo_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
                        strobes.grc = 1'b1; strobes.r_out = 1'b1;
                        strobes.alu_op = opcode; strobes.zlow_in = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        strobes.c_out = 1'b1; strobes.alu_op = opcode; strobes.zlow_in = 1'b1;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        strobes.c_out = 1'b1; strobes.alu_op = ALU_OP_ADD; strobes.zlow_in = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
`ifdef CU_MULDIV_EN
                    OP_MUL, OP_DIV: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.alu_op = opcode;
                        strobes.zhigh_in = 1'b1; strobes.zlow_in = 1'b1;
                    end
`endif
                    OP_BRX: begin
                        strobes.pc_out = 1'b1; strobes.y_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        strobes.zlow_out = 1'b1; strobes.mar_enable = 1'b1;
                    end
`ifdef CU_MULDIV_EN
                    OP_MUL, OP_DIV: begin
                        strobes.zlow_out = 1'b1; strobes.lo_enable = 1'b1;
                    end
`endif
                    OP_BRX: begin
                        strobes.c_out = 1'b1; strobes.alu_op = ALU_OP_ADD; strobes.zlow_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (opcode)
                    OP_LD: begin
                        strobes.mdr_read = 1'b1; strobes.mdr_enable = 1'b1;
                    end
                    // Store path: register value goes onto the bus, MDR loads from bus.
                    OP_ST: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_enable = 1'b1;
                    end
`ifdef CU_MULDIV_EN
                    OP_MUL, OP_DIV: begin
                        strobes.zhigh_out = 1'b1; strobes.hi_enable = 1'b1;
                    end
`endif
                    OP_BRX: begin
                        strobes.zlow_out  = con_ff;
                        strobes.pc_enable = con_ff;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (opcode)
                    OP_LD: begin
                        strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    OP_ST: strobes.ram_write = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT: strobes.run = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: T0..T7 step register plus Moore strobe decode.
// CU_MULDIV_EN (see cpu_pkg) enables the mul/div execute sequence.
import cpu_pkg::*;

module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        LOout,
    output logic        HIout,
    output logic        InPortout,
    output logic        BAout,
    output logic        Cout,
    output logic        R_out,
    output logic        PC_enable,
    output logic        IncPC,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        MDR_read,
    output logic        RAM_write,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        R_in,
    output logic        CON_enable,
    output logic        OutPort_enable,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [4:0]  ALU_op,
    output logic        Run
);

    state_t     state_reg;
    state_t     state_next;
    strobes_t   strobes;
    logic [4:0] opcode;
    logic [2:0] n_exec;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign n_exec    = exec_cycles(opcode);
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) state_reg <= ST_RST;
        else       state_reg <= state_next;
    end

    // Each execute step returns to T0 once the opcode's step count is used up.
    always_comb begin
        state_next = ST_RST;
        case (state_reg)
            ST_RST:  state_next = ST_T0;
            ST_T0:   state_next = ST_T1;
            ST_T1:   state_next = ST_T2;
            ST_T2:   state_next = ST_T3;
            ST_T3:   state_next = (opcode == OP_HALT) ? ST_HALT :
                                  (n_exec == 3'd1)    ? ST_T0   : ST_T4;
            ST_T4:   state_next = (n_exec == 3'd2) ? ST_T0 : ST_T5;
            ST_T5:   state_next = (n_exec == 3'd3) ? ST_T0 : ST_T6;
            ST_T6:   state_next = (n_exec == 3'd4) ? ST_T0 : ST_T7;
            ST_T7:   state_next = ST_T0;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase
    end

    cu_step_decode u_decode (
        .state   (state_reg),
        .opcode  (opcode),
        .con_ff  (CON_FF),
        .strobes (strobes)
    );

    always_comb begin
        PCout          = strobes.pc_out;
        MDRout         = strobes.mdr_out;
        ZLowout        = strobes.zlow_out;
        ZHighout       = strobes.zhigh_out;
        LOout          = strobes.lo_out;
        HIout          = strobes.hi_out;
        InPortout      = strobes.inport_out;
        BAout          = strobes.ba_out;
        Cout           = strobes.c_out;
        R_out          = strobes.r_out;
        PC_enable      = strobes.pc_enable;
        IncPC          = strobes.inc_pc;
        MAR_enable     = strobes.mar_enable;
        MDR_enable     = strobes.mdr_enable;
        MDR_read       = strobes.mdr_read;
        RAM_write      = strobes.ram_write;
        IR_enable      = strobes.ir_enable;
        Y_enable       = strobes.y_enable;
        ZLowIn         = strobes.zlow_in;
        ZHighIn        = strobes.zhigh_in;
        HI_enable      = strobes.hi_enable;
        LO_enable      = strobes.lo_enable;
        R_in           = strobes.r_in;
        CON_enable     = strobes.con_enable;
        OutPort_enable = strobes.outport_enable;
        Gra            = strobes.gra;
        Grb            = strobes.grb;
        Grc            = strobes.grc;
        ALU_op         = strobes.alu_op;
        Run            = strobes.run;
    end

endmodule

// File: tb/tb_control_unit.sv
// Table-driven check of control_unit strobe sequences, plus halt and mid-instruction Clear cases.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        CON_FF;
    logic PCout, MDRout, ZLowout, ZHighout, LOout, HIout, InPortout, BAout, Cout, R_out;
    logic PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, RAM_write, IR_enable, Y_enable;
    logic ZLowIn, ZHighIn, HI_enable, LO_enable, R_in, CON_enable, OutPort_enable;
    logic Gra, Grb, Grc, Run;
    logic [4:0] ALU_op;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
        .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout),
        .LOout(LOout), .HIout(HIout), .InPortout(InPortout), .BAout(BAout),
        .Cout(Cout), .R_out(R_out), .PC_enable(PC_enable), .IncPC(IncPC),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .MDR_read(MDR_read),
        .RAM_write(RAM_write), .IR_enable(IR_enable), .Y_enable(Y_enable),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HI_enable(HI_enable), .LO_enable(LO_enable),
        .R_in(R_in), .CON_enable(CON_enable), .OutPort_enable(OutPort_enable),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALU_op(ALU_op), .Run(Run)
    );

    always #5 Clock = ~Clock;

    logic [33:0] obs;
    assign obs = {PCout, MDRout, ZLowout, ZHighout, LOout, HIout, InPortout, BAout, Cout, R_out,
                  PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, RAM_write, IR_enable,
                  Y_enable, ZLowIn, ZHighIn, HI_enable, LO_enable, R_in, CON_enable,
                  OutPort_enable, Gra, Grb, Grc, Run, ALU_op};

    localparam logic [33:0] ONE   = 34'd1;
    localparam logic [33:0] PCO   = ONE << 33, MDRO = ONE << 32, ZLO  = ONE << 31, ZHO  = ONE << 30;
    localparam logic [33:0] LOO   = ONE << 29, HIO  = ONE << 28, INO  = ONE << 27, BAO  = ONE << 26;
    localparam logic [33:0] COUT  = ONE << 25, ROUT = ONE << 24, PCE  = ONE << 23, INCPC = ONE << 22;
    localparam logic [33:0] MARE  = ONE << 21, MDRE = ONE << 20, MDRR = ONE << 19, RAMW = ONE << 18;
    localparam logic [33:0] IRE   = ONE << 17, YEN  = ONE << 16, ZLI  = ONE << 15, ZHI  = ONE << 14;
    localparam logic [33:0] HIE   = ONE << 13, LOE  = ONE << 12, RIN  = ONE << 11, CONE = ONE << 10;
    localparam logic [33:0] OPE   = ONE << 9,  GRA  = ONE << 8,  GRB  = ONE << 7,  GRC  = ONE << 6;
    localparam logic [33:0] RUN   = ONE << 5;

    localparam logic [33:0] W_T0 = PCO | MARE | INCPC | ZLI | RUN;
    localparam logic [33:0] W_T1 = ZLO | PCE | MDRR | MDRE | RUN;
    localparam logic [33:0] W_T2 = MDRO | IRE | RUN;

    function automatic logic [33:0] alu(input logic [4:0] v);
        return {29'd0, v};
    endfunction

    typedef struct {
        string            name;
        logic [31:0]      ir;
        logic             con;
        int               len;
        logic [4:0][33:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [31:0] ir, input logic con, input int len,
                                input logic [33:0] e3, input logic [33:0] e4, input logic [33:0] e5,
                                input logic [33:0] e6, input logic [33:0] e7);
        vec_t v;
        v.name = n; v.ir = ir; v.con = con; v.len = len;
        v.exp[0] = e3; v.exp[1] = e4; v.exp[2] = e5; v.exp[3] = e6; v.exp[4] = e7;
        return v;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [33:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic do_reset(input string name);
        Clear = 1'b1;
        @(negedge Clock);
        chk({name, "_rst"}, RUN);
        Clear = 1'b0;
    endtask

    task automatic fetch(input string name);
        @(negedge Clock); chk({name, "_T0"}, W_T0);
        @(negedge Clock); chk({name, "_T1"}, W_T1);
        @(negedge Clock); chk({name, "_T2"}, W_T2);
    endtask

    vec_t tbl[$];

    initial begin
        Clear = 1'b1; IR = '0; CON_FF = 1'b0;
        #12 chk("reset_state", RUN);

        tbl.push_back(mk("addi", 32'h59080002, 0, 3, GRB|ROUT|YEN, COUT|alu(5'b01011)|ZLI, ZLO|GRA|RIN, 0, 0));
        tbl.push_back(mk("add",  32'h18000000, 0, 3, GRB|ROUT|YEN, GRC|ROUT|alu(5'b00011)|ZLI, ZLO|GRA|RIN, 0, 0));
        tbl.push_back(mk("sub",  32'h20000000, 0, 3, GRB|ROUT|YEN, GRC|ROUT|alu(5'b00100)|ZLI, ZLO|GRA|RIN, 0, 0));
        tbl.push_back(mk("ori",  32'h68000000, 0, 3, GRB|ROUT|YEN, COUT|alu(5'b01101)|ZLI, ZLO|GRA|RIN, 0, 0));
        tbl.push_back(mk("ldi",  32'h08000000, 0, 3, GRB|BAO|YEN, COUT|alu(5'b00011)|ZLI, ZLO|GRA|RIN, 0, 0));
        tbl.push_back(mk("ld",   32'h00000000, 0, 5, GRB|BAO|YEN, COUT|alu(5'b00011)|ZLI, ZLO|MARE,
                         MDRR|MDRE, MDRO|GRA|RIN));
        tbl.push_back(mk("st",   32'h10000000, 0, 5, GRB|BAO|YEN, COUT|alu(5'b00011)|ZLI, ZLO|MARE,
                         GRA|ROUT|MDRE, RAMW));
        tbl.push_back(mk("neg",  32'h80000000, 0, 2, GRB|ROUT|alu(5'b10000)|ZLI, ZLO|GRA|RIN, 0, 0, 0));
        tbl.push_back(mk("not",  32'h88000000, 0, 2, GRB|ROUT|alu(5'b10001)|ZLI, ZLO|GRA|RIN, 0, 0, 0));
        tbl.push_back(mk("brx0", 32'h90000000, 0, 4, GRA|ROUT|CONE, PCO|YEN, COUT|alu(5'b00011)|ZLI, 0, 0));
        tbl.push_back(mk("brx1", 32'h90000000, 1, 4, GRA|ROUT|CONE, PCO|YEN, COUT|alu(5'b00011)|ZLI, ZLO|PCE, 0));
        tbl.push_back(mk("jr",   32'h98000000, 0, 1, GRA|ROUT|PCE, 0, 0, 0, 0));
        tbl.push_back(mk("in",   32'hA8000000, 0, 1, INO|GRA|RIN, 0, 0, 0, 0));
        tbl.push_back(mk("out",  32'hB0000000, 0, 1, GRA|ROUT|OPE, 0, 0, 0, 0));
        tbl.push_back(mk("mfhi", 32'hB8000000, 0, 1, HIO|GRA|RIN, 0, 0, 0, 0));
        tbl.push_back(mk("mflo", 32'hC1000000, 0, 1, LOO|GRA|RIN, 0, 0, 0, 0));
        tbl.push_back(mk("nop",  32'hC8000000, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("undef", 32'hA0000000, 0, 1, 0, 0, 0, 0, 0));
`ifdef CU_MULDIV_EN
        tbl.push_back(mk("mul",  32'h70000000, 0, 4, GRA|ROUT|YEN, GRB|ROUT|alu(5'b01110)|ZHI|ZLI,
                         ZLO|LOE, ZHO|HIE, 0));
        tbl.push_back(mk("div",  32'h78000000, 0, 4, GRA|ROUT|YEN, GRB|ROUT|alu(5'b01111)|ZHI|ZLI,
                         ZLO|LOE, ZHO|HIE, 0));
`else
        tbl.push_back(mk("mul",  32'h70000000, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("div",  32'h78000000, 0, 1, 0, 0, 0, 0, 0));
`endif

        foreach (tbl[i]) begin
            IR = tbl[i].ir;
            CON_FF = tbl[i].con;
            do_reset(tbl[i].name);
            fetch(tbl[i].name);
            for (int s = 0; s < tbl[i].len; s++) begin
                @(negedge Clock);
                chk($sformatf("%s_T%0d", tbl[i].name, s + 3), tbl[i].exp[s] | RUN);
            end
            @(negedge Clock);
            chk({tbl[i].name, "_next_T0"}, W_T0);
            $display("vector %s done: errors so far %0d", tbl[i].name, errors);
        end

        // halt: T3 quiet, then HALT with Run low until Clear
        IR = 32'hD0000000;
        do_reset("halt");
        fetch("halt");
        @(negedge Clock); chk("halt_T3", RUN);
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            chk($sformatf("halt_hold%0d", c), 34'd0);
        end
        Clear = 1'b1;
        #1 chk("halt_clear_async", RUN);
        @(negedge Clock); Clear = 1'b0;
        @(negedge Clock); chk("halt_restart_T0", W_T0);
        $display("sequence halt done: errors so far %0d", errors);

        // Clear during T5 of ld drops strobes without waiting for a clock edge
        IR = 32'h00000000;
        do_reset("ldclr");
        fetch("ldclr");
        @(negedge Clock); chk("ldclr_T3", GRB|BAO|YEN|RUN);
        @(negedge Clock); chk("ldclr_T4", COUT|alu(5'b00011)|ZLI|RUN);
        @(negedge Clock); chk("ldclr_T5", ZLO|MARE|RUN);
        #1 Clear = 1'b1;
        #1 chk("ldclr_async", RUN);
        @(negedge Clock); Clear = 1'b0;
        @(negedge Clock); chk("ldclr_restart_T0", W_T0);
        @(negedge Clock); chk("ldclr_restart_T1", W_T1);
        $display("sequence ld_clear done: errors so far %0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Mini SRC datapath. It sits directly upstream of `datapath`, reads the instruction register and the CON flip-flop, and drives every datapath control strobe one step per clock (T0..T7). It replaces hand-sequenced stimulus with real fetch/decode/execute sequencing. Outputs are Moore-decoded from the state register.

## Interface
- No parameters. Opcode and state encodings come from `cpu_pkg`.
- Clock: in, 1 bit. Rising-edge clock.
- Clear: in, 1 bit. Asynchronous, active-high reset.
- IR: in, 32 bits. Instruction register contents. Opcode is `IR[31:27]`.
- CON_FF: in, 1 bit. Branch condition result.
- PCout, MDRout, ZLowout, ZHighout, LOout, HIout, InPortout, BAout, Cout, R_out: out, 1 bit each. Bus-driver enables.
- PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, RAM_write, IR_enable, Y_enable, ZLowIn, ZHighIn, HI_enable, LO_enable, R_in, CON_enable, OutPort_enable: out, 1 bit each. Load and control strobes.
- Gra, Grb, Grc: out, 1 bit each. Register-field selects.
- ALU_op: out, 5 bits. ALU operation. Opcode encoding; ADD = 00011.
- Run: out, 1 bit. 1 = executing, 0 = halted.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- RST exits to T0 on the first Clock edge after Clear falls.
- Fetch:
  - T0: PCout, MAR_enable, IncPC, ZLowIn.
  - T1: ZLowout, PC_enable, MDR_read, MDR_enable.
  - T2: MDRout, IR_enable.
- Opcodes (5 bits): add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, brx 10010, jr 10011, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010, ld 00000, ldi 00001, st 00010.
- In every sequence below, ALU_op is 0 unless stated.
- Execute sequences (the last listed step returns to T0):
  - R-type (add..or): T3 Grb+R_out+Y_enable. T4 Grc+R_out+ALU_op=opcode+ZLowIn. T5 ZLowout+Gra+R_in.
  - Immediate (addi/andi/ori): as R-type, except T4 uses Cout in place of Grc+R_out.
  - ldi: T3 Grb+BAout+Y_enable. T4 Cout+ALU_op=ADD+ZLowIn. T5 ZLowout+Gra+R_in.
  - ld: T3/T4 as ldi. T5 ZLowout+MAR_enable. T6 MDR_read+MDR_enable. T7 MDRout+Gra+R_in.
  - st: T3–T5 as ld. T6 Gra+R_out+MDR_enable with MDR_read=0. T7 RAM_write.
  - neg/not: T3 Grb+R_out+ALU_op+ZLowIn. T4 ZLowout+Gra+R_in.
  - mul/div: T3 Gra+R_out+Y_enable. T4 Grb+R_out+ALU_op+ZHighIn+ZLowIn. T5 ZLowout+LO_enable. T6 ZHighout+HI_enable.
  - brx: T3 Gra+R_out+CON_enable. T4 PCout+Y_enable. T5 Cout+ALU_op=ADD+ZLowIn. T6 ZLowout+PC_enable only if CON_FF=1; otherwise all strobes 0.
  - jr: T3 Gra+R_out+PC_enable.
  - in: T3 InPortout+Gra+R_in.
  - out: T3 Gra+R_out+OutPort_enable.
  - mfhi: T3 HIout+Gra+R_in.
  - mflo: T3 LOout+Gra+R_in.
  - nop and undefined opcodes: T3 with all strobes 0.
  - halt: T3 → HALT. HALT holds all strobes 0 and Run=0 until Clear.

## Timing
- One step per clock. Outputs change only after a Clock edge or on Clear.
- Instruction latency is 3 fetch cycles plus the execute cycles:
  - 1 execute cycle: jr, in, out, mfhi, mflo, nop.
  - 2 execute cycles: neg, not.
  - 3 execute cycles: R-type, immediate, ldi.
  - 4 execute cycles: mul, div, brx.
  - 5 execute cycles: ld, st.
- The opcode is sampled from IR during T3..T7. IR is stable because IR_enable is asserted only in T2.
- CON_FF is sampled in T6; it was loaded by CON_enable in T3.
- Reset value of every output is 0, except Run=1.
- Clear asserted mid-instruction forces RST and zeroes all strobes immediately. A partially executed instruction is abandoned, and fetch restarts at T0 after Clear releases.

## Configuration
- `CU_MULDIV_EN` defined: mul and div execute the 4-cycle sequence above.
- `CU_MULDIV_EN` undefined: mul and div decode as nop (T3 with all strobes 0, then T0). No ZHighIn, HI_enable or LO_enable is ever asserted.

## Structure
- `cpu_pkg` holds:
  - the opcode localparams;
  - the state enum (RST..HALT);
  - the ALU_OP_ADD constant.
- Sub-module `cu_step_decode` is purely combinational. It maps {state, opcode, CON_FF} to the strobe vector.
- `control_unit` owns the state register and the next-state logic.

## Test plan
- After Clear, the first edges produce T0 (PCout, MAR_enable, IncPC, ZLowIn), then T1, then T2 with IR_enable=1.
- IR=0x59080002 (addi r2,r1,2):
  - T3: Grb, R_out, Y_enable.
  - T4: Cout, ALU_op=01011, ZLowIn.
  - T5: ZLowout, Gra, R_in.
  - The next cycle is T0.
- IR=0xC1000000 (mflo r2): T3 asserts LOout, Gra and R_in only; the next cycle is T0.
- brx with CON_FF=0 in T6: PC_enable stays 0 throughout. With CON_FF=1, T6 asserts ZLowout and PC_enable.
- IR=0xD0000000 (halt): Run falls to 0 and all strobes stay 0 for 20 cycles. Clear restores Run=1 and restarts at T0.
- Clear pulsed during T5 of ld: MAR_enable and ZLowout drop immediately. With `CU_MULDIV_EN` undefined, a mul opcode gives an all-zero T3 and then T0.
